// File: rtl/fdc_host_bridge_pkg.sv
// Shared types and constants for the floppy-controller host bridge.
package fdc_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RELEASE = 2'd2
    } strobe_state_t;

    // Bit positions inside the drive control register.
    localparam int HALT_EN_BIT = 7;
    localparam int DS3_BIT     = 6;
    localparam int DENSITY_BIT = 5;
    localparam int PRECOMP_BIT = 4;
    localparam int MOTOR_BIT   = 3;

    localparam logic [7:0] DEFAULT_SDC_MAGIC = 8'h43;

    // Lowest selected drive among {ds3, ds2, ds1, ds0} that actually exists,
    // as 1..num_drives; 0 when nothing is selected or the SDC handoff value is written.
    function automatic logic [2:0] drive_decode(input logic [7:0] value,
                                                input logic [7:0] magic,
                                                input int         num_drives);
        logic [3:0] sel;
        drive_decode = 3'd0;
        sel = {value[DS3_BIT], value[2:0]};
        if (value != magic) begin
            for (int i = 3; i >= 0; i--) begin
                if (i < num_drives && sel[i]) drive_decode = 3'(i + 1);
            end
        end
    endfunction

endpackage

// File: rtl/fdc_host_bridge_if.sv
// Bridge-to-controller bus for up to four WD1793-style controllers.
// Handshake: a per-drive strobe (fdc_rd/fdc_wr) acts as "valid" and holds
// fdc_addr/fdc_din stable; the controller accepts it on the one fdc_ce tick
// that the strobe overlaps ("ready"), and the strobe drops on the next cycle.
interface fdc_host_bridge_if #(
    parameter int NUM_DRIVES = 4
);
    logic                    fdc_ce;
    logic [NUM_DRIVES-1:0]   fdc_rd;
    logic [NUM_DRIVES-1:0]   fdc_wr;
    logic [1:0]              fdc_addr;
    logic [7:0]              fdc_din;
    logic [8*NUM_DRIVES-1:0] fdc_dout;
    logic [NUM_DRIVES-1:0]   fdc_drq;
    logic [NUM_DRIVES-1:0]   fdc_intrq;

    modport master (
        output fdc_ce, fdc_rd, fdc_wr, fdc_addr, fdc_din,
        input  fdc_dout, fdc_drq, fdc_intrq
    );

    modport slave (
        input  fdc_ce, fdc_rd, fdc_wr, fdc_addr, fdc_din,
        output fdc_dout, fdc_drq, fdc_intrq
    );
endinterface

// File: rtl/fdc_strobe_fsm.sv
// Synchronises CPU request levels and turns each rising request into a single
// controller strobe that overlaps exactly one controller enable tick.
module fdc_strobe_fsm
    import fdc_bridge_pkg::*;
#(
    parameter int NUM_DRIVES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic                  sdc_en,
    input  logic                  fdc_ce,
    input  logic [1:0]            address,
    input  logic [7:0]            data_in,
    input  logic [2:0]            drive_index,
    output logic [NUM_DRIVES-1:0] rd_strobe,
    output logic [NUM_DRIVES-1:0] wr_strobe,
    output logic [1:0]            addr,
    output logic [7:0]            din,
    output logic                  launch,
    output strobe_state_t         state
);

    logic          rd_s1, rd_s2, rd_s3;
    logic          wr_s1, wr_s2, wr_s3;
    logic          rd_rise, wr_rise;
    logic          lat_rd;
    logic [2:0]    lat_drive;
    strobe_state_t state_next;

    assign rd_rise = rd_s2 & ~rd_s3;
    assign wr_rise = wr_s2 & ~wr_s3;

    // Two-flop synchronisers plus a history flop for edge detection; SDC ownership blocks new requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rd_s1, rd_s2, rd_s3} <= 3'b000;
            {wr_s1, wr_s2, wr_s3} <= 3'b000;
        end else begin
            rd_s1 <= rd_req & ~sdc_en;
            rd_s2 <= rd_s1;
            rd_s3 <= rd_s2;
            wr_s1 <= wr_req & ~sdc_en;
            wr_s2 <= wr_s1;
            wr_s3 <= wr_s2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Capture the target and payload when an operation launches; later control writes cannot retarget it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= 2'd0;
            din       <= 8'h00;
            lat_drive <= 3'd0;
            lat_rd    <= 1'b0;
        end else if (launch) begin
            addr      <= address;
            din       <= data_in;
            lat_drive <= drive_index;
            lat_rd    <= rd_rise;
        end
    end

    // Next state: launch on a request edge, leave ARMED after the enable tick, re-arm only once both requests drop.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_rise || wr_rise) begin
                    launch     = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fdc_ce) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!rd_s2 && !wr_s2) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobe decode from registered state, so reset removes it asynchronously.
    always_comb begin
        rd_strobe = '0;
        wr_strobe = '0;
        if (state == ST_ARMED) begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (lat_drive == 3'(i + 1)) begin
                    rd_strobe[i] = lat_rd;
                    wr_strobe[i] = ~lat_rd;
                end
            end
        end
    end

endmodule

// File: rtl/fdc_host_bridge.sv
// CPU-to-floppy-controller bridge: control register, controller clock enable,
// request strobing, per-drive status/data multiplexing and motor-off timeout.
module fdc_host_bridge
    import fdc_bridge_pkg::*;
#(
    parameter int          NUM_DRIVES    = 4,
    parameter int          CE_DIV        = 6,
    parameter logic [23:0] MOTOR_TIMEOUT = 24'd8000000,
    parameter logic [7:0]  SDC_MAGIC     = DEFAULT_SDC_MAGIC
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [1:0]        ADDRESS,
    input  logic [7:0]        DATA_IN,
    input  logic              CTRL_WR,
    input  logic              FDC_RD_REQ,
    input  logic              FDC_WR_REQ,
    input  logic              SDC_EN,
    fdc_host_bridge_if.master fdc,
    output logic [7:0]        ctrl_value,
    output logic [2:0]        drive_index,
    output logic              side,
    output logic              motor_on,
    output logic [7:0]        DATA_OUT,
    output logic              HALT,
    output logic              NMI,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(CE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);
    localparam logic [23:0]      TMO_LAST = MOTOR_TIMEOUT - 24'd1;
    localparam bit               TMO_EN   = (MOTOR_TIMEOUT != 24'd0);

    logic [CNT_W-1:0] ce_cnt;
    logic [23:0]      tmo_cnt;
    logic             tmo_fire;
    logic             drq_sel;
    logic             intrq_sel;
    logic             launch;
    strobe_state_t    fsm_state;

    // Controller enable divider: one single-cycle tick every CE_DIV clocks.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)              ce_cnt <= '0;
        else if (ce_cnt == CNT_LAST) ce_cnt <= '0;
        else                       ce_cnt <= ce_cnt + 1'b1;
    end

    assign fdc.fdc_ce = (ce_cnt == CNT_LAST);

    assign tmo_fire = TMO_EN && fdc.fdc_ce && ctrl_value[MOTOR_BIT] && (tmo_cnt == TMO_LAST);

    // Inactivity counter in enable ticks; restarts on any control write or launched operation, saturates at the limit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            tmo_cnt <= 24'd0;
        else if (CTRL_WR || launch)
            tmo_cnt <= 24'd0;
        else if (fdc.fdc_ce && ctrl_value[MOTOR_BIT] && (tmo_cnt != TMO_LAST))
            tmo_cnt <= tmo_cnt + 24'd1;
    end

    // Control register: CPU write beats the motor timeout, a pending INTRQ on the selected drive beats both for halt_en.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_value  <= 8'h00;
            drive_index <= 3'd0;
        end else begin
            if (CTRL_WR) begin
                ctrl_value  <= DATA_IN;
                drive_index <= drive_decode(DATA_IN, SDC_MAGIC, NUM_DRIVES);
            end else if (tmo_fire) begin
                ctrl_value[MOTOR_BIT] <= 1'b0;
            end
            if (intrq_sel) ctrl_value[HALT_EN_BIT] <= 1'b0;
        end
    end

    // Per-drive status and read-data multiplexer for the currently selected drive.
    always_comb begin
        drq_sel   = 1'b0;
        intrq_sel = 1'b0;
        DATA_OUT  = 8'h00;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (drive_index == 3'(i + 1)) begin
                drq_sel   = fdc.fdc_drq[i];
                intrq_sel = fdc.fdc_intrq[i];
                DATA_OUT  = fdc.fdc_dout[8*i +: 8];
            end
        end
    end

    // With four drives bit 6 is the fourth drive select, so there is no side bit.
    assign side     = (NUM_DRIVES == 4) ? 1'b0 : ctrl_value[DS3_BIT];
    assign motor_on = ctrl_value[MOTOR_BIT];
    assign HALT     = ~SDC_EN & ctrl_value[HALT_EN_BIT] & (drive_index != 3'd0) & ~drq_sel;
    assign NMI      = ~SDC_EN & ctrl_value[DENSITY_BIT] & intrq_sel;
    assign busy     = (fsm_state != ST_IDLE);

    fdc_strobe_fsm #(
        .NUM_DRIVES (NUM_DRIVES)
    ) u_strobe (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .rd_req      (FDC_RD_REQ),
        .wr_req      (FDC_WR_REQ),
        .sdc_en      (SDC_EN),
        .fdc_ce      (fdc.fdc_ce),
        .address     (ADDRESS),
        .data_in     (DATA_IN),
        .drive_index (drive_index),
        .rd_strobe   (fdc.fdc_rd),
        .wr_strobe   (fdc.fdc_wr),
        .addr        (fdc.fdc_addr),
        .din         (fdc.fdc_din),
        .launch      (launch),
        .state       (fsm_state)
    );

endmodule
